// File: rtl/key_bank_if.sv
// key_bank_if: raw key pins in, debounced key events out.
// master drives the raw keys, slave is the key bank itself.
interface key_bank_if #(
  parameter int KEY_NUM = 3
);
  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;
  logic [KEY_NUM-1:0] key_level;
  logic               any_press;

  modport master (
    output key_in,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_level,
    input  any_press
  );

  modport slave (
    input  key_in,
    output key_press,
    output key_release,
    output key_long,
    output key_level,
    output any_press
  );
endinterface

// File: rtl/key_bank.sv
// key_bank: per-channel key sync, debounce, long-press and repeat events.
// Define KEY_BANK_REPEAT_EN to emit auto-repeat presses while held.
module key_bank #(
  parameter int KEY_NUM      = 3,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input logic       clk,
  input logic       rst,
  key_bank_if.slave kb
);

  localparam int DL_MAX  = (DEBOUNCE_CYC > LONG_CYC)
                         ? DEBOUNCE_CYC : LONG_CYC;
  localparam int CNT_MAX = (DL_MAX > REPEAT_CYC)
                         ? DL_MAX : REPEAT_CYC;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] DB_END   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_END = CW'(LONG_CYC - 1);
`ifdef KEY_BANK_REPEAT_EN
  localparam logic [CW-1:0] RPT_END  = CW'(REPEAT_CYC - 1);
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DB_DOWN = 3'd1;
  localparam logic [2:0] S_HELD    = 3'd2;
  localparam logic [2:0] S_REPEAT  = 3'd3;
  localparam logic [2:0] S_DB_UP   = 3'd4;

  logic [KEY_NUM-1:0] press_e;
  logic [KEY_NUM-1:0] rel_e;
  logic [KEY_NUM-1:0] long_e;
  logic [KEY_NUM-1:0] lvl_e;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    logic [1:0]    sync;
    logic          act;
    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ld, ld_n;
    logic          p_q, r_q, l_q, v_q;
    logic          p_n, r_n, l_n, v_n;

    assign act = sync[1] ^ ACTIVE_LOW;

    always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      ld_n    = ld;
      p_n     = 1'b0;
      r_n     = 1'b0;
      l_n     = 1'b0;
      v_n     = v_q;
      unique case (state)
        S_IDLE: begin
          cnt_n = '0;
          if (act) state_n = S_DB_DOWN;
        end
        S_DB_DOWN: begin
          if (!act) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (cnt == DB_END) begin
            state_n = S_HELD;
            cnt_n   = '0;
            p_n     = 1'b1;
            v_n     = 1'b1;
            ld_n    = 1'b0;
          end
        end
        S_HELD: begin
          if (!act) begin
            state_n = S_DB_UP;
            cnt_n   = '0;
          end else if (cnt == LONG_END && !ld) begin
            state_n = S_REPEAT;
            cnt_n   = '0;
            l_n     = 1'b1;
            ld_n    = 1'b1;
          end
        end
        S_REPEAT: begin
          if (!act) begin
            state_n = S_DB_UP;
            cnt_n   = '0;
`ifdef KEY_BANK_REPEAT_EN
          end else if (cnt == RPT_END) begin
            cnt_n = '0;
            p_n   = 1'b1;
          end
`else
          end else begin
            cnt_n = cnt;
          end
`endif
        end
        S_DB_UP: begin
          if (act) begin
            // bounce while releasing: resume the hold phase already reached
            state_n = ld ? S_REPEAT : S_HELD;
            cnt_n   = '0;
          end else if (cnt == DB_END) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            r_n     = 1'b1;
            v_n     = 1'b0;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync  <= {2{ACTIVE_LOW}};
        state <= S_IDLE;
        cnt   <= '0;
        ld    <= 1'b0;
        p_q   <= 1'b0;
        r_q   <= 1'b0;
        l_q   <= 1'b0;
        v_q   <= 1'b0;
      end else begin
        sync  <= {sync[0], kb.key_in[g]};
        state <= state_n;
        cnt   <= cnt_n;
        ld    <= ld_n;
        p_q   <= p_n;
        r_q   <= r_n;
        l_q   <= l_n;
        v_q   <= v_n;
      end
    end

    assign press_e[g] = p_q;
    assign rel_e[g]   = r_q;
    assign long_e[g]  = l_q;
    assign lvl_e[g]   = v_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kb.key_press   <= '0;
      kb.key_release <= '0;
      kb.key_long    <= '0;
      kb.key_level   <= '0;
      kb.any_press   <= 1'b0;
    end else begin
      kb.key_press   <= press_e;
      kb.key_release <= rel_e;
      kb.key_long    <= long_e;
      kb.key_level   <= lvl_e;
      kb.any_press   <= |press_e;
    end
  end

endmodule

// File: doc/key_bank.md
# key_bank

Parametrised multi-channel key front end for the alarm-clock design. It replaces per-key debounce instances with a single bank of `KEY_NUM` independent channels. Each channel synchronises, debounces and classifies a raw push-button into press, release, long-press and auto-repeat events. It sits between the board keys and the time/alarm adjust logic, so adjust/add/sub can support fast taps, held keys and accelerated stepping.

## Interface
- `KEY_NUM`, 3: number of key channels, 1..16.
- `ACTIVE_LOW`, 1: 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed.
- `DEBOUNCE_CYC`, 1_000_000: stable-level cycles required to accept a press or release (20 ms at 50 MHz), ≥2.
- `LONG_CYC`, 50_000_000: held cycles after an accepted press before `key_long` fires, ≥2.
- `REPEAT_CYC`, 10_000_000: auto-repeat period after a long press, ≥2.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_in`  in  KEY_NUM  raw asynchronous key levels.
- `key_press`  out  KEY_NUM  one-cycle pulse per accepted press and per auto-repeat step.
- `key_release`  out  KEY_NUM  one-cycle pulse per accepted release.
- `key_long`  out  KEY_NUM  one-cycle pulse when the hold reaches `LONG_CYC`.
- `key_level`  out  KEY_NUM  debounced level, 1 = pressed.
- `any_press`  out  1  registered OR of `key_press`, same cycle as the pulses.

## Operation
- Per channel, a 2-flop synchroniser feeds the FSM. `act` = synchronised level after `ACTIVE_LOW` polarity correction.
- Per channel there is one counter of width $clog2(max(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC)) and one `long_done` bit.
- Every state change clears the counter.
- IDLE: if `act`, go to DB_DOWN.
- DB_DOWN:
  - `!act` → IDLE. No pulse; glitch rejected.
  - Counter reaches DEBOUNCE_CYC-1 with `act` → HELD, `key_press`=1, `key_level`←1, `long_done`←0.
- HELD:
  - `!act` → DB_UP.
  - Counter reaches LONG_CYC-1 and `!long_done` → `key_long`=1, `long_done`←1, go to REPEAT.
- REPEAT:
  - `!act` → DB_UP.
  - Counter reaches REPEAT_CYC-1 → `key_press`=1, counter restarts. Period is exactly `REPEAT_CYC`.
- DB_UP:
  - `act` → back to HELD if `!long_done`, else REPEAT. No pulses; the timer restarts.
  - Counter reaches DEBOUNCE_CYC-1 with `!act` → IDLE, `key_release`=1, `key_level`←0.
- Channels are fully independent. Simultaneous events on several channels each pulse in their own bit. `any_press` is high if any bit pulses.
- `key_press`, `key_long` and `key_release` are never high together on one channel.

## Timing
- All outputs are registered. Reset value is 0 for every output. Synchronisers reset to the released level. FSMs reset to IDLE.
- Press latency: `key_press` is high DEBOUNCE_CYC+3 cycles after the first rising `clk` that samples the pressed raw level. That is 2 synchroniser cycles, DEBOUNCE_CYC counting cycles and 1 output register cycle.
- Release latency is DEBOUNCE_CYC+3 cycles by the same rule.
- `key_long` fires LONG_CYC cycles after the `key_press` cycle, with no intervening bounce.
- First repeat `key_press` fires REPEAT_CYC cycles after `key_long`, then every REPEAT_CYC cycles.
- Reset asserted mid-operation: outputs drop to 0 asynchronously. No `key_release` is emitted for a key held across reset. After deassertion, a still-held key produces a fresh press after DEBOUNCE_CYC+3 cycles.

## Configuration
- `KEY_BANK_REPEAT_EN` defined: behaviour exactly as above. REPEAT emits auto-repeat `key_press` pulses.
- `KEY_BANK_REPEAT_EN` undefined:
  - REPEAT still exists but never emits `key_press` and never restarts its counter.
  - `key_long` still fires once per hold.
  - `REPEAT_CYC` is ignored and the repeat logic is not synthesised.

## Test plan
Use `KEY_NUM`=3, `ACTIVE_LOW`=1, `DEBOUNCE_CYC`=4, `LONG_CYC`=20, `REPEAT_CYC`=8.

- Clean tap: `key_in[0]` low for 12 cycles, then high.
  - → `key_press[0]` one pulse 7 cycles after the first low sample.
  - → `key_level[0]` high for exactly 12 cycles.
  - → `key_release[0]` one pulse.
  - → no `key_long`.
- Glitch: `key_in[1]` low for 3 cycles, then high → no pulses, `key_level[1]` stays 0.
- Bounce on release: held 30 cycles, then high 2, low 2, high 10.
  - → a single `key_release`.
  - → `key_long` pulses once, not repeated after the bounce.
- Long hold with `KEY_BANK_REPEAT_EN` defined: low for 60 cycles.
  - → `key_press` at cycle 7.
  - → `key_long` at cycle 27.
  - → repeat `key_press` at cycles 35, 43, 51, 59, and more if still held.
  - Repeat with the macro undefined → only the cycle-7 press and the cycle-27 long pulse.
- Simultaneous: all three keys pressed on the same cycle → `key_press`=3'b111 in one cycle, `any_press`=1 in that cycle.
- Reset mid-hold: assert `rst` during REPEAT.
  - → all outputs 0 immediately, no `key_release`.
  - → after release of `rst` with the key still low, a new `key_press` comes 7 cycles later.
